// File: rtl/pe_stream_loader_if.sv
// pe_stream_loader_if
// Bundles the PE controller request/config lines, the shared memory read
// port, the weight and input buffer push streams and the finish levels of
// one per-PE stream loader.
//   master : the loader side (issues reads, pushes words, reports finish)
//   slave  : the environment side (controller, memory, buffers)
`timescale 1ns/1ps

interface pe_stream_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10,
    parameter int K_W    = 4
) ();
    // PE controller request and layer configuration
    logic              req_filter_valid;
    logic [K_W-1:0]    req_filter_k;
    logic              req_input_valid;
    logic [ADDR_W-1:0] cfg_filter_base;
    logic [LEN_W-1:0]  cfg_filter_len;
    logic [ADDR_W-1:0] cfg_input_base;
    logic [LEN_W-1:0]  cfg_input_len;
    // shared on-chip memory read port (data one cycle after the strobe)
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    // weight buffer push
    logic              wt_valid;
    logic [DATA_W-1:0] wt_data;
    logic              wt_ready;
    // input buffer push
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    // completion levels back to the controller
    logic              stream_filter_finish;
    logic              stream_input_finish;

    modport master (
        input  req_filter_valid, req_filter_k, req_input_valid,
        input  cfg_filter_base, cfg_filter_len, cfg_input_base, cfg_input_len,
        input  mem_rd_data, wt_ready, in_ready,
        output mem_rd_en, mem_rd_addr,
        output wt_valid, wt_data, in_valid, in_data,
        output stream_filter_finish, stream_input_finish
    );

    modport slave (
        output req_filter_valid, req_filter_k, req_input_valid,
        output cfg_filter_base, cfg_filter_len, cfg_input_base, cfg_input_len,
        output mem_rd_data, wt_ready, in_ready,
        input  mem_rd_en, mem_rd_addr,
        input  wt_valid, wt_data, in_valid, in_data,
        input  stream_filter_finish, stream_input_finish
    );
endinterface

// File: rtl/pe_stream_loader.sv
// pe_stream_loader
// Per-PE stream engine. On a filter request it streams the compressed words
// of filter group k from the shared memory into the weight buffer; on an
// input request it streams the input activation block into the input buffer.
// Each channel reports completion as a level that stays high until its
// request drops.
// Ports:
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : pe_stream_loader_if.master (requests, config, memory read port,
//          weight/input push streams, finish levels)
// Optional build macro STREAM_LOADER_PERF_EN adds:
//   perf_stall_cycles : cycles with an active channel blocked by its buffer
//   perf_words        : completed weight + input pushes
//   (both 32-bit, saturating, cleared only by reset)
`timescale 1ns/1ps

// One stream channel: start/length capture, read issue, 2-entry output FIFO.
module pe_stream_channel #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              grant,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              ready,
    output logic              want,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              finish
`ifdef STREAM_LOADER_PERF_EN
    ,
    output logic              busy,
    output logic              pop
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  remain_r;
    logic              inflight_r;
    logic [1:0]        count_r;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] tail_r;

    logic              pop_s;
    logic [2:0]        occ_s;
    logic              active_s;
    logic              abort_s;
    logic              want_s;
    logic              issue_s;

    // Issue qualification. The occupancy counts the word leaving this cycle
    // as already gone, so a full-rate stream never bubbles while the FIFO
    // plus the in-flight read still never exceed two entries.
    always_comb begin
        pop_s    = (count_r != 2'd0) && ready;
        occ_s    = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        active_s = (state_r == ST_FETCH) || (state_r == ST_DRAIN);
        abort_s  = active_s && !req_valid;
        want_s   = (state_r == ST_FETCH) && req_valid && (occ_s < 3'd2);
        issue_s  = want_s && grant;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (len == {LEN_W{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!req_valid) begin
                    state_s = ST_IDLE;
                end else if (issue_s && (remain_r == {{(LEN_W-1){1'b0}}, 1'b1})) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // leave one cycle early when the last buffered word is popping now
                if (!req_valid) begin
                    state_s = ST_IDLE;
                end else if (!inflight_r &&
                             ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s))) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!req_valid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Address/length counters, in-flight tracking and the 2-entry FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_r     <= {ADDR_W{1'b0}};
            remain_r   <= {LEN_W{1'b0}};
            inflight_r <= 1'b0;
            count_r    <= 2'd0;
            head_r     <= {DATA_W{1'b0}};
            tail_r     <= {DATA_W{1'b0}};
        end else begin
            // parameters are captured only while idle
            if ((state_r == ST_IDLE) && req_valid) begin
                addr_r   <= start_addr;
                remain_r <= len;
            end else if (issue_s) begin
                addr_r   <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                remain_r <= remain_r - {{(LEN_W-1){1'b0}}, 1'b1};
            end

            if (abort_s) begin
                // dropping the in-flight flag discards the returning word
                inflight_r <= 1'b0;
                count_r    <= 2'd0;
            end else begin
                inflight_r <= issue_s;
                case ({inflight_r, pop_s})
                    2'b10: begin
                        if (count_r == 2'd0) begin
                            head_r <= rd_data;
                        end else begin
                            tail_r <= rd_data;
                        end
                        count_r <= count_r + 2'd1;
                    end
                    2'b01: begin
                        head_r  <= tail_r;
                        count_r <= count_r - 2'd1;
                    end
                    2'b11: begin
                        if (count_r == 2'd1) begin
                            head_r <= rd_data;
                        end else begin
                            head_r <= tail_r;
                            tail_r <= rd_data;
                        end
                    end
                    default: begin
                        count_r <= count_r;
                    end
                endcase
            end
        end
    end

    assign want    = want_s;
    assign rd_addr = addr_r;
    assign valid   = (count_r != 2'd0);
    assign data    = head_r;
    assign finish  = (state_r == ST_DONE);
`ifdef STREAM_LOADER_PERF_EN
    assign busy    = active_s;
    assign pop     = pop_s;
`endif
endmodule

module pe_stream_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10,
    parameter int K_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_stream_loader_if.master   bus
`ifdef STREAM_LOADER_PERF_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_words
`endif
);
    localparam int PW = K_W + LEN_W;
    localparam int SW = ADDR_W + PW;

    logic [PW-1:0]     f_prod_s;
    logic [ADDR_W-1:0] f_start_s;
    logic              f_want_s;
    logic              i_want_s;
    logic [ADDR_W-1:0] f_addr_s;
    logic [ADDR_W-1:0] i_addr_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              f_valid_s;
    logic              i_valid_s;
    logic [DATA_W-1:0] f_data_s;
    logic [DATA_W-1:0] i_data_s;
    logic              f_finish_s;
    logic              i_finish_s;
`ifdef STREAM_LOADER_PERF_EN
    logic              f_busy_s;
    logic              i_busy_s;
    logic              f_pop_s;
    logic              i_pop_s;
`endif

    // Filter group start: base + k*len, wrapped to the address width.
    always_comb begin
        f_prod_s  = {{LEN_W{1'b0}}, bus.req_filter_k} * {{K_W{1'b0}}, bus.cfg_filter_len};
        f_start_s = ADDR_W'({{PW{1'b0}}, bus.cfg_filter_base} + {{ADDR_W{1'b0}}, f_prod_s});
    end

    pe_stream_channel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_filter (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (bus.req_filter_valid),
        .start_addr (f_start_s),
        .len        (bus.cfg_filter_len),
        .grant      (1'b1),
        .rd_data    (bus.mem_rd_data),
        .ready      (bus.wt_ready),
        .want       (f_want_s),
        .rd_addr    (f_addr_s),
        .valid      (f_valid_s),
        .data       (f_data_s),
        .finish     (f_finish_s)
`ifdef STREAM_LOADER_PERF_EN
        ,
        .busy       (f_busy_s),
        .pop        (f_pop_s)
`endif
    );

    // The input channel only gets the read port when the filter channel idles it.
    pe_stream_channel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_input (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (bus.req_input_valid),
        .start_addr (bus.cfg_input_base),
        .len        (bus.cfg_input_len),
        .grant      (!f_want_s),
        .rd_data    (bus.mem_rd_data),
        .ready      (bus.in_ready),
        .want       (i_want_s),
        .rd_addr    (i_addr_s),
        .valid      (i_valid_s),
        .data       (i_data_s),
        .finish     (i_finish_s)
`ifdef STREAM_LOADER_PERF_EN
        ,
        .busy       (i_busy_s),
        .pop        (i_pop_s)
`endif
    );

    // Shared read port address, filter first; parked at zero when unused.
    always_comb begin
        rd_addr_s = {ADDR_W{1'b0}};
        if (f_want_s) begin
            rd_addr_s = f_addr_s;
        end else if (i_want_s) begin
            rd_addr_s = i_addr_s;
        end else begin
            rd_addr_s = {ADDR_W{1'b0}};
        end
    end

    assign bus.mem_rd_en            = f_want_s || i_want_s;
    assign bus.mem_rd_addr          = rd_addr_s;
    assign bus.wt_valid             = f_valid_s;
    assign bus.wt_data              = f_data_s;
    assign bus.in_valid             = i_valid_s;
    assign bus.in_data              = i_data_s;
    assign bus.stream_filter_finish = f_finish_s;
    assign bus.stream_input_finish  = i_finish_s;

`ifdef STREAM_LOADER_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] words_cnt_r;
    logic        stall_s;
    logic [1:0]  words_inc_s;
    logic [32:0] words_sum_s;

    // Per-cycle stall flag and push count feeding the counters.
    always_comb begin
        stall_s     = (f_busy_s && f_valid_s && !bus.wt_ready) ||
                      (i_busy_s && i_valid_s && !bus.in_ready);
        words_inc_s = {1'b0, f_pop_s} + {1'b0, i_pop_s};
        words_sum_s = {1'b0, words_cnt_r} + {31'd0, words_inc_s};
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
            words_cnt_r <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (words_sum_s[32]) begin
                words_cnt_r <= 32'hFFFF_FFFF;
            end else begin
                words_cnt_r <= words_sum_s[31:0];
            end
        end
    end

    assign perf_stall_cycles = stall_cnt_r;
    assign perf_words        = words_cnt_r;
`endif
endmodule

// File: tb/tb_pe_stream_loader.sv
`timescale 1ns/1ps

module tb_pe_stream_loader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 10;
    localparam int K_W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .K_W(K_W)) bus ();

`ifdef STREAM_LOADER_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_words;
`endif

    pe_stream_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .K_W(K_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef STREAM_LOADER_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_words        (perf_words)
`endif
    );

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
        logic [K_W-1:0]    k;
        logic [ADDR_W-1:0] exp_start;
        int                exp_lat;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] wt_exp[$];
    logic [DATA_W-1:0] in_exp[$];
    logic [ADDR_W-1:0] rd_log[$];
    logic [ADDR_W-1:0] rd_exp[$];
    int issued = 0;
    int pushed = 0;
    int wt_pushes = 0;
    bit occ_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    // memory contents: every address holds a distinct recognisable word
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {4'hA, a};
    endfunction

    // memory with one cycle read latency; garbage when not read
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_rd_addr);
        else               bus.mem_rd_data <= 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // observe the cycle about to be clocked: handshakes, reads, stalls
    task automatic sample();
        if (stall_prev) begin
            check("wt_hold_valid", 32'(bus.wt_valid), 32'd1);
            check("wt_hold_data", 32'(bus.wt_data), 32'(stall_data));
        end
        if (occ_en) check("occupancy_le2", 32'((issued - pushed) <= 2), 32'd1);
        if (bus.wt_valid && bus.wt_ready) begin
            if (wt_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL wt_extra got=%0h expected=no word", bus.wt_data);
            end else begin
                check("wt_data", 32'(bus.wt_data), 32'(wt_exp.pop_front()));
            end
            wt_pushes++; pushed++;
        end
        if (bus.in_valid && bus.in_ready) begin
            if (in_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL in_extra got=%0h expected=no word", bus.in_data);
            end else begin
                check("in_data", 32'(bus.in_data), 32'(in_exp.pop_front()));
            end
            pushed++;
        end
        if (bus.mem_rd_en) begin
            rd_log.push_back(bus.mem_rd_addr);
            issued++;
        end
        stall_prev = bus.wt_valid && !bus.wt_ready;
        stall_data = bus.wt_data;
    endtask

    task automatic tick();
        #1;
        sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_filter(input vec_t v);
        bus.cfg_filter_base = v.base;
        bus.cfg_filter_len  = v.len;
        bus.req_filter_k    = v.k;
        rd_log.delete();
        rd_exp.delete();
        for (int i = 0; i < int'(v.len); i++) begin
            rd_exp.push_back(v.exp_start + ADDR_W'(i));
            wt_exp.push_back(mem_word(v.exp_start + ADDR_W'(i)));
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_nreads"}, 32'(rd_log.size()), 32'(rd_exp.size()));
        for (int i = 0; i < rd_exp.size() && i < rd_log.size(); i++)
            check({tag, "_rdaddr"}, 32'(rd_log[i]), 32'(rd_exp[i]));
    endtask

    task automatic run_filter(input vec_t v, input string tag);
        int lat;
        load_filter(v);
        bus.req_filter_valid = 1'b1;
        lat = 0;
        while (!bus.stream_filter_finish && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_left"}, 32'(wt_exp.size()), 32'd0);
        check_reads(tag);
        tick();
        check({tag, "_hold"}, 32'(bus.stream_filter_finish), 32'd1);
        bus.req_filter_valid = 1'b0;
        tick();
        check({tag, "_clear"}, 32'(bus.stream_filter_finish), 32'd0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'd0);
        check({tag, "_wt_valid"}, 32'(bus.wt_valid), 32'd0);
        check({tag, "_wt_data"}, 32'(bus.wt_data), 32'd0);
        check({tag, "_in_valid"}, 32'(bus.in_valid), 32'd0);
        check({tag, "_in_data"}, 32'(bus.in_data), 32'd0);
        check({tag, "_ffin"}, 32'(bus.stream_filter_finish), 32'd0);
        check({tag, "_ifin"}, 32'(bus.stream_input_finish), 32'd0);
    endtask

    // interrupt a len=8 stream after two pushes, by valid drop or by reset
    task automatic run_abort(input bit use_reset, input string tag);
        vec_t v;
        int n;
        v = '{12'h400, 10'd8, 4'd0, 12'h400, 11};
        load_filter(v);
        wt_pushes = 0;
        bus.req_filter_valid = 1'b1;
        n = 0;
        while (wt_pushes < 2 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, 32'(wt_pushes >= 2), 32'd1);
        if (use_reset) begin
            rst = 1'b0;
            tick();
            check_all_zero(tag);
            rst = 1'b1;
        end else begin
            bus.req_filter_valid = 1'b0;
            tick();
            check({tag, "_nofin"}, 32'(bus.stream_filter_finish), 32'd0);
            check({tag, "_wt_valid"}, 32'(bus.wt_valid), 32'd0);
            check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        end
        bus.req_filter_valid = 1'b0;
        wt_exp.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_flushed"}, 32'(bus.wt_valid), 32'd0);
        end
        run_filter(v, {tag, "_restart"});
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        int f_lat;
        int i_lat;
        logic [3:0] pat;

        vecs[0] = '{12'h100, 10'd4, 4'd3,  12'h10C, 7};   // basic filter
        vecs[1] = '{12'hFFE, 10'd4, 4'd0,  12'hFFE, 7};   // address wrap
        vecs[2] = '{12'h000, 10'd0, 4'd5,  12'h000, 1};   // zero length
        vecs[3] = '{12'h050, 10'd1, 4'd2,  12'h052, 4};   // single word
        vecs[4] = '{12'hFF0, 10'd5, 4'd15, 12'h03B, 8};   // start wraps

        bus.req_filter_valid = 1'b0;
        bus.req_filter_k     = '0;
        bus.req_input_valid  = 1'b0;
        bus.cfg_filter_base  = '0;
        bus.cfg_filter_len   = '0;
        bus.cfg_input_base   = '0;
        bus.cfg_input_len    = '0;
        bus.wt_ready         = 1'b1;
        bus.in_ready         = 1'b1;
        bus.mem_rd_data      = '0;

        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) run_filter(vecs[v], $sformatf("vec%0d", v));

        // backpressure: ready follows 1,0,0,1 while a 6-word stream runs
        pat = 4'b1001;
        load_filter('{12'h300, 10'd6, 4'd0, 12'h300, 0});
        issued = 0;
        pushed = 0;
        occ_en = 1'b1;
        bus.req_filter_valid = 1'b1;
        n = 0;
        while (!bus.stream_filter_finish && n < 200) begin
            bus.wt_ready = pat[n % 4];
            tick();
            n++;
        end
        occ_en = 1'b0;
        bus.wt_ready = 1'b1;
        check("bp_finish", 32'(bus.stream_filter_finish), 32'd1);
        check("bp_left", 32'(wt_exp.size()), 32'd0);
        check_reads("bp");
        bus.req_filter_valid = 1'b0;
        tick();
        check("bp_clear", 32'(bus.stream_filter_finish), 32'd0);
        tick();

        // both channels together: filter reads first, input reads after
        load_filter('{12'h100, 10'd3, 4'd1, 12'h103, 0});
        rd_exp.push_back(12'h200);
        rd_exp.push_back(12'h201);
        in_exp.push_back(mem_word(12'h200));
        in_exp.push_back(mem_word(12'h201));
        bus.cfg_input_base = 12'h200;
        bus.cfg_input_len  = 10'd2;
        bus.req_filter_valid = 1'b1;
        bus.req_input_valid  = 1'b1;
        n = 0;
        f_lat = 0;
        i_lat = 0;
        while (!bus.stream_input_finish && n < 100) begin
            tick();
            n++;
            if (bus.stream_filter_finish && f_lat == 0) f_lat = n;
        end
        i_lat = n;
        check("both_f_lat", 32'(f_lat), 32'd6);
        check("both_i_lat", 32'(i_lat), 32'd8);
        check("both_f_at_i", 32'(bus.stream_filter_finish), 32'd1);
        check("both_wt_left", 32'(wt_exp.size()), 32'd0);
        check("both_in_left", 32'(in_exp.size()), 32'd0);
        check_reads("both");
        tick();
        tick();
        check("both_hold_f", 32'(bus.stream_filter_finish), 32'd1);
        check("both_hold_i", 32'(bus.stream_input_finish), 32'd1);
        bus.req_filter_valid = 1'b0;
        bus.req_input_valid  = 1'b0;
        tick();
        check("both_clear_f", 32'(bus.stream_filter_finish), 32'd0);
        check("both_clear_i", 32'(bus.stream_input_finish), 32'd0);
        tick();

        run_abort(1'b0, "abort");
        run_abort(1'b1, "rstmid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_stream_loader.md
# pe_stream_loader

Per-PE stream engine that serves the PE controller's `Req_Stream` requests. It fetches one filter group (weights of output channel k) and, on the first conv layer, the input activation block from the shared on-chip memory. It pushes each word into the PE's weight and input buffers over valid/ready and returns the `Stream_filter_finish` / `Stream_input_finish_PE` levels the controller waits on. It sits directly downstream of the PE controller and upstream of the PE multiplier array buffers.

## Interface
- DATA_W, 16, memory/buffer word width (compressed value+index)
- ADDR_W, 12, memory address width
- LEN_W, 10, words-per-stream length width
- K_W, 4, filter index width (`max_num_K` = 2^K_W)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the rising clk edge)
- req_filter_valid  in  1  `Req_Stream_filter_valid` from PE controller
- req_filter_k  in  K_W  filter group index
- req_input_valid  in  1  `Req_Stream_input_valid`
- cfg_filter_base  in  ADDR_W  filter region base for current layer
- cfg_filter_len  in  LEN_W  compressed words per filter group
- cfg_input_base  in  ADDR_W  input region base
- cfg_input_len  in  LEN_W  input words
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- wt_valid / wt_data / wt_ready  out/out/in  1/DATA_W/1  weight buffer push
- in_valid / in_data / in_ready  out/out/in  1/DATA_W/1  input buffer push
- stream_filter_finish  out  1  filter stream complete (level)
- stream_input_finish  out  1  input stream complete (level)

## Operation
- Two independent channels, F (filter) and I (input). Each has FSM IDLE, FETCH, DRAIN, DONE.
- IDLE: on request valid high, latch start address and length. Then go to FETCH, or straight to DONE if length==0.
  - F start address = cfg_filter_base + req_filter_k*cfg_filter_len, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - I start address = cfg_input_base.
- FETCH: issue reads at consecutive addresses; address increments wrap modulo 2^ADDR_W. After the last read is issued, go to DRAIN.
- Each channel has a 2-entry output FIFO. A read may issue only when fifo_count + inflight < 2, so the FIFO never overflows.
- Shared read port, fixed priority: F wins. I issues only in cycles where F does not.
- DRAIN: wait until the FIFO is empty and no read is in flight, then go to DONE.
- DONE: finish output held high while the request valid stays high. When valid drops, return to IDLE and clear finish in the same edge.
- Request valid dropping during FETCH/DRAIN aborts the channel:
  - stop issuing, discard in-flight data, flush the FIFO;
  - go to IDLE next cycle; finish is never asserted.
- Request parameters are sampled only in IDLE. Changes to them mid-stream are ignored.
- A new request needs valid low for at least one cycle after DONE (re-arm rule).
- Reset values: all FSMs IDLE; FIFOs empty; mem_rd_en, wt_valid, in_valid, stream_filter_finish, stream_input_finish = 0; mem_rd_addr, wt_data, in_data = 0.

## Timing
- Request seen high at cycle N in IDLE → FETCH at N+1; first mem_rd_en at N+1.
- Data is captured into the FIFO at the end of N+2; wt_valid/in_valid high at N+3.
- With ready held high and no contention: one word per cycle. A stream of L words has its last push at N+2+L and finish high at N+3+L.
- Length 0: finish high at N+1.
- ready low: the FIFO fills to 2 and issue stalls. Valid and data stay stable until ready.
- Both channels requested together: F completes with full throughput. I progresses only in F bubbles and after F leaves FETCH.
- Reset mid-stream: everything returns to reset values at the next edge. The data returned for a read issued before reset is dropped.

## Configuration
- STREAM_LOADER_PERF_EN defined: add outputs perf_stall_cycles and perf_words (32-bit each).
  - perf_stall_cycles counts cycles where any channel is in FETCH/DRAIN with valid && !ready.
  - perf_words counts completed wt+in handshakes (2 per cycle max).
  - Both saturate at all-ones and clear only on reset.
- Not defined: those ports and counters do not exist. All other behaviour is identical.

## Test plan
- Filter only: base=0x100, len=4, k=3, ready=1. Expect reads 0x10C..0x10F, wt_data in that order, finish at request cycle+7. Drop valid → finish 0 next cycle.
- Layer 0, both channels: filter len=3, input base=0x200 len=2. Filter reads issue first with no I reads in between. Input pushes follow. Both finish high simultaneously held until valid low.
- Backpressure: wt_ready toggles 1-0-0-1 pattern, len=6. No lost or duplicated words. At most 2 reads outstanding-or-buffered. wt_data stable while stalled.
- Wrap: base=0xFFE, k=0, len=4. Addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Abort and reset: drop filter valid after 2 words of len=8. No finish, FIFO empty, next request restarts from its start address. Repeat with rst low mid-stream. All outputs 0 next cycle.
- Zero length: cfg_filter_len=0. No mem_rd_en; finish at N+1.
